// File: rtl/shift_pipe.sv
// shift_pipe -- two-stage barrel shifter with valid/ready handshakes on both sides.
//
// Stage 1 registers the coarse shift (amount[4:3] x 8 bits). It also registers
// the op, the fill bit and the fine amount with the data. Stage 2 applies the
// fine shift (amount[2:0]) and holds the registered result for writeback.
//
// Ops: 00 SLL, 01 SRL, 11 SRA, 10 pass-through (operand returned unchanged).
//
// Configuration macro: SHIFT_PIPE_SRA_EN
//   defined   -> op 11 fills vacated bits with i_rs1[31] (arithmetic shift)
//   undefined -> op 11 behaves exactly like SRL (zero fill)
//
// Ports:
//   i_clk      sole clock, rising edge
//   i_rst      synchronous active-high reset
//   i_valid    upstream offers an operation
//   o_ready    an offered operation is taken this cycle
//   i_op       shift operation code
//   i_rs1      operand to shift
//   i_amount   shift amount 0..31
//   i_rd       destination tag, carried through unmodified
//   o_valid    result available to writeback
//   i_ready    writeback takes the result this cycle
//   o_data     shift result
//   o_rd       tag belonging to o_data

module shift_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [31:0]      i_rs1,
    input  logic [4:0]       i_amount,
    input  logic [TAG_W-1:0] i_rd,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_data,
    output logic [TAG_W-1:0] o_rd
);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_PASS = 2'b10,
        OP_SRA  = 2'b11
    } op_e;

    // Stage 1 state
    logic             r_s1_valid;
    op_e              r_s1_op;
    logic             r_s1_fill;
    logic [2:0]       r_s1_fine;
    logic [31:0]      r_s1_data;
    logic [TAG_W-1:0] r_s1_rd;

    // Stage 2 state (drives the outputs directly)
    logic             r_s2_valid;
    logic [31:0]      r_s2_data;
    logic [TAG_W-1:0] r_s2_rd;

    // Handshake
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // Pipeline control: an empty stage always advances, so bubbles collapse.
    assign w_s2_adv = !r_s2_valid || i_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = i_valid && w_s1_adv;
    assign o_ready  = w_s1_adv;

    // ---------------------------------------------------------------
    // Stage 1 combinational: coarse shift
    // ---------------------------------------------------------------
    op_e         w_op;
    logic        w_fill;
    logic [4:0]  w_coarse;
    logic [31:0] w_rmask1;
    logic [31:0] w_s1_data;

    assign w_op     = op_e'(i_op);
    assign w_coarse = {i_amount[4:3], 3'b000};

`ifdef SHIFT_PIPE_SRA_EN
    assign w_fill = (w_op == OP_SRA) && i_rs1[31];
`else
    assign w_fill = 1'b0;
`endif

    // Ones in the bit positions vacated by a right shift of w_coarse.
    assign w_rmask1 = ~(32'hFFFF_FFFF >> w_coarse);

    always_comb begin
        w_s1_data = i_rs1;
        case (w_op)
            OP_SLL:         w_s1_data = i_rs1 << w_coarse;
            OP_SRL, OP_SRA: w_s1_data = (i_rs1 >> w_coarse) | (w_rmask1 & {32{w_fill}});
            default:        w_s1_data = i_rs1;
        endcase
    end

    // ---------------------------------------------------------------
    // Stage 2 combinational: fine shift on stage-1 registers only
    // ---------------------------------------------------------------
    logic [31:0] w_rmask2;
    logic [31:0] w_s2_data;

    assign w_rmask2 = ~(32'hFFFF_FFFF >> r_s1_fine);

    always_comb begin
        w_s2_data = r_s1_data;
        case (r_s1_op)
            OP_SLL:         w_s2_data = r_s1_data << r_s1_fine;
            OP_SRL, OP_SRA: w_s2_data = (r_s1_data >> r_s1_fine) | (w_rmask2 & {32{r_s1_fill}});
            default:        w_s2_data = r_s1_data;
        endcase
    end

    // ---------------------------------------------------------------
    // Sequential
    // ---------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make stage order matter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= 32'h0000_0000;
            r_s2_rd    <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= i_valid;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_s2_data;
                    r_s2_rd   <= r_s1_rd;
                end
            end
        end
    end

    // NOTE: stage-1 payload has no reset; it is only observed through
    // r_s1_valid, which is reset, so clearing it would add logic for nothing.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_s1_op   <= w_op;
            r_s1_fill <= w_fill;
            r_s1_fine <= i_amount[2:0];
            r_s1_data <= w_s1_data;
            r_s1_rd   <= i_rd;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_data  = r_s2_data;
    assign o_rd    = r_s2_rd;

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the destination-register tag carried alongside each operation.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  upstream (decode) presents an operation.
REQ-005 SHALL have port o_ready  output  1  block accepts operation this cycle.
REQ-006 SHALL have port i_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved.
REQ-007 SHALL have port i_rs1  input  32  operand to shift.
REQ-008 SHALL have port i_amount  input  5  shift amount, unsigned 0..31.
REQ-009 SHALL have port i_rd  input  TAG_W  destination tag, passed through unmodified.
REQ-010 SHALL have port o_valid  output  1  result available to writeback.
REQ-011 SHALL have port i_ready  input  1  writeback accepts result this cycle.
REQ-012 SHALL have port o_data  output  32  shift result.
REQ-013 SHALL have port o_rd  output  TAG_W  tag matching o_data.

Function
REQ-014 SHALL transfer an operation in when i_valid && o_ready, and a result out when o_valid && i_ready.
REQ-015 SHALL implement a two-stage pipeline: S1 applies the coarse shift (i_amount[4:3] x 8 bits); S2 applies the fine shift (i_amount[2:0]) and drives o_data/o_rd/o_valid from registers.
REQ-016 SHALL have latency of exactly 2 cycles from accept to o_valid when no stall occurs; throughput 1 op/cycle sustained.
REQ-017 SHALL compute SLL as i_rs1 << amount, zero-filled.
REQ-018 SHALL compute SRL as i_rs1 >> amount, zero-filled.
REQ-019 SHALL compute SRA as i_rs1 >> amount, filled with i_rs1[31] (behaviour per REQ-033/034).
REQ-020 SHALL pass i_rs1 through unchanged for op 10.
REQ-021 SHALL, for amount 0, output i_rs1 unchanged for every op.
REQ-022 SHALL carry op, fill bit and remaining amount bits from S1 to S2 with the data; no input is re-sampled after acceptance.
REQ-023 SHALL advance S2 when S2 is empty or i_ready=1; SHALL advance S1 when S1 is empty or S2 advances.
REQ-024 SHALL drive o_ready = (S1 empty) || (S2 advances); combinational path i_ready -> o_ready is permitted.
REQ-025 SHALL hold o_data, o_rd, o_valid stable while o_valid=1 and i_ready=0.
REQ-026 SHALL collapse bubbles: an empty S2 is filled from a valid S1 regardless of i_ready.
REQ-027 SHALL, on simultaneous accept and output with both stages full, shift all stages by one with no loss or duplication.
REQ-028 SHALL never reorder operations; o_rd sequence equals i_rd acceptance sequence.

Reset
REQ-029 SHALL, on i_rst=1 at a rising edge, clear both stage valid bits; o_valid=0 next cycle.
REQ-030 SHALL reset o_data to 32'h0000_0000 and o_rd to 0.
REQ-031 SHALL discard in-flight operations when reset asserts mid-operation; no result emerges for them.
REQ-032 SHALL drive o_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, with macro SHIFT_PIPE_SRA_EN defined, implement SRA sign fill per REQ-019.
REQ-034 SHALL, with SHIFT_PIPE_SRA_EN undefined, execute op 11 identically to SRL (zero fill); all other behaviour unchanged.

Verification
REQ-035 SHALL verify: SRL i_rs1=32'h8000_0000 amount=31 -> o_data=32'h0000_0001 exactly 2 cycles after accept.
REQ-036 SHALL verify: SRA i_rs1=32'hF000_0000 amount=4 -> 32'hFF00_0000 with SHIFT_PIPE_SRA_EN, 32'h0F00_0000 without.
REQ-037 SHALL verify: SLL i_rs1=32'h0000_0001 amount=0,8,31 back-to-back -> 32'h0000_0001, 32'h0000_0100, 32'h8000_0000 on consecutive cycles, tags in order.
REQ-038 SHALL verify: i_ready=0 for 5 cycles with 3 ops offered -> two accepted, o_ready=0 until release, o_data held stable, no loss after release.
REQ-039 SHALL verify: i_rst=1 with both stages full -> o_valid=0 and o_data=0 next cycle, discarded ops never emerge, o_ready=1 after deassert.
REQ-040 SHALL verify: op 10 i_rs1=32'hDEAD_BEEF amount=13 -> o_data=32'hDEAD_BEEF.
